// File: rtl/riscv_mem_pkg.sv
// Shared constants and owner encoding for the data-memory path.
// Imported by the dmem arbiter, its grant logic and its port interface.
package riscv_mem_pkg;

  localparam int DMEM_ADDR_WIDTH = 14;
  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_WE_WIDTH   = DMEM_DATA_WIDTH / 8;
  localparam int DBG_WAIT_WIDTH  = 4;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response port of the dmem arbiter; one instance per requester.
// A requester uses the master modport, the arbiter uses the slave modport.
interface dmem_arbiter_if
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH
);

  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] we;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req_valid, addr, we, wdata,
    input  req_ready, rvalid, rdata
  );

  modport slave (
    input  req_valid, addr, we, wdata,
    output req_ready, rvalid, rdata
  );

endinterface

// File: rtl/arb2_prio_rr.sv
// Two-input grant logic: fixed CPU priority with a bounded debug wait, or
// round-robin. Bit 0 of the request/grant vectors is the CPU, bit 1 debug.
module arb2_prio_rr
  import riscv_mem_pkg::*;
#(
  parameter int CPU_PRIORITY = 1,
  parameter int MAX_DBG_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  localparam logic [DBG_WAIT_WIDTH-1:0] W_MAX_WAIT = DBG_WAIT_WIDTH'(MAX_DBG_WAIT);
  localparam logic [DBG_WAIT_WIDTH-1:0] W_SAT     = {DBG_WAIT_WIDTH{1'b1}};

  owner_e                    r_last_grant;
  logic [DBG_WAIT_WIDTH-1:0] r_dbg_wait_cnt;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    o_grant = 2'b00;
    if (rst) begin
      o_grant = 2'b00;
    end else if (i_req == 2'b11) begin
      if (CPU_PRIORITY != 0) begin
        o_grant = (r_dbg_wait_cnt == W_MAX_WAIT) ? 2'b10 : 2'b01;
      end else begin
        o_grant = (r_last_grant == OWNER_DBG) ? 2'b01 : 2'b10;
      end
    end else begin
      o_grant = i_req;
    end
  end

  // Last-grant history and the debug starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant   <= OWNER_DBG;
      r_dbg_wait_cnt <= '0;
    end else begin
      if (o_grant[1]) begin
        r_last_grant <= OWNER_DBG;
      end else if (o_grant[0]) begin
        r_last_grant <= OWNER_CPU;
      end else begin
        r_last_grant <= r_last_grant;
      end

      if (!i_req[1] || o_grant[1]) begin
        r_dbg_wait_cnt <= '0;
      end else if (r_dbg_wait_cnt != W_SAT) begin
        r_dbg_wait_cnt <= r_dbg_wait_cnt + 4'd1;
      end else begin
        r_dbg_wait_cnt <= r_dbg_wait_cnt;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem BRAM between the CPU and the debug loader port.
// Muxes the granted request onto the BRAM and steers the next-cycle response.
module dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DMEM_DATA_WIDTH,
  parameter int CPU_PRIORITY = 1,
  parameter int MAX_DBG_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  dmem_arbiter_if.slave           cpu,
  dmem_arbiter_if.slave           dbg,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic       w_rsp_live;
  logic       w_cpu_rvalid;
  logic       w_dbg_rvalid;

  logic       r_resp_pend;
  owner_e     r_resp_owner;
  logic       r_resp_read;

  assign w_req = {dbg.req_valid, cpu.req_valid};

  arb2_prio_rr #(
    .CPU_PRIORITY (CPU_PRIORITY),
    .MAX_DBG_WAIT (MAX_DBG_WAIT)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  assign cpu.req_ready = w_grant[OWNER_CPU];
  assign dbg.req_ready = w_grant[OWNER_DBG];

  // Request mux onto the BRAM; idle cycles park on the CPU address/data.
  always_comb begin
    mem_en   = |w_grant;
    mem_we   = '0;
    mem_addr = cpu.addr;
    mem_din  = cpu.wdata;
    if (w_grant[OWNER_DBG]) begin
      mem_we   = dbg.we;
      mem_addr = dbg.addr;
      mem_din  = dbg.wdata;
    end else if (w_grant[OWNER_CPU]) begin
      mem_we = cpu.we;
    end else begin
      mem_we = '0;
    end
  end

  // Remember who owns the response arriving from the BRAM next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_pend  <= 1'b0;
      r_resp_owner <= OWNER_CPU;
      r_resp_read  <= 1'b0;
    end else begin
      r_resp_pend  <= mem_en;
      r_resp_owner <= w_grant[OWNER_DBG] ? OWNER_DBG : OWNER_CPU;
      r_resp_read  <= (mem_we == '0);
    end
  end

  // A response still pending when reset arrives is dropped, not delivered.
  assign w_rsp_live   = r_resp_pend & ~rst;
  assign w_cpu_rvalid = w_rsp_live & (r_resp_owner == OWNER_CPU);
  assign w_dbg_rvalid = w_rsp_live & (r_resp_owner == OWNER_DBG);

  assign cpu.rvalid = w_cpu_rvalid;
  assign dbg.rvalid = w_dbg_rvalid;
  assign cpu.rdata  = (w_cpu_rvalid && r_resp_read) ? mem_dout : '0;
  assign dbg.rdata  = (w_dbg_rvalid && r_resp_read) ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a priority-mode and a round-robin instance share one
// request stream; a transaction-level model predicts grants and responses.
module tb_dmem_arbiter;
  import riscv_mem_pkg::*;

  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int WEW  = 4;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_if ();
  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbg_if ();
  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu2_if ();
  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbg2_if ();

  logic           mem_en, rr_mem_en;
  logic [WEW-1:0] mem_we, rr_mem_we;
  logic [AW-1:0]  mem_addr, rr_mem_addr;
  logic [DW-1:0]  mem_din, rr_mem_din, mem_dout, rr_mem_dout;

  assign rr_mem_dout       = 32'h0;
  assign cpu2_if.req_valid = cpu_if.req_valid;
  assign cpu2_if.addr      = cpu_if.addr;
  assign cpu2_if.we        = cpu_if.we;
  assign cpu2_if.wdata     = cpu_if.wdata;
  assign dbg2_if.req_valid = dbg_if.req_valid;
  assign dbg2_if.addr      = dbg_if.addr;
  assign dbg2_if.we        = dbg_if.we;
  assign dbg2_if.wdata     = dbg_if.wdata;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_PRIORITY(1), .MAX_DBG_WAIT(MAXW)) u_dut (
    .clk(clk), .rst(rst), .cpu(cpu_if), .dbg(dbg_if),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_PRIORITY(0), .MAX_DBG_WAIT(MAXW)) u_rr (
    .clk(clk), .rst(rst), .cpu(cpu2_if), .dbg(dbg2_if),
    .mem_en(rr_mem_en), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr), .mem_din(rr_mem_din),
    .mem_dout(rr_mem_dout)
  );

  // Read-first byte-writable BRAM behind the priority-mode instance.
  bit [DW-1:0] bram [0:16383];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= bram[mem_addr];
      for (int i = 0; i < WEW; i++)
        if (mem_we[i]) bram[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: memory image, pending response, arbitration history.
  bit [DW-1:0] shadow [0:16383];
  int          m_wait  = 0;
  bit          m_last  = 1'b1;
  bit          m_gc, m_gd, m_rgc, m_rgd;
  bit          m_pend  = 1'b0;
  bit          m_owner = 1'b0;
  logic [DW-1:0] m_rdata = 32'h0;

  task automatic model_eval();
    bit cv, dv;
    cv = cpu_if.req_valid; dv = dbg_if.req_valid;
    m_gc = 1'b0; m_gd = 1'b0; m_rgc = 1'b0; m_rgd = 1'b0;
    if (!rst) begin
      if (cv && dv) begin
        if (m_wait == MAXW) m_gd = 1'b1; else m_gc = 1'b1;
        if (m_last) m_rgc = 1'b1; else m_rgd = 1'b1;
      end else begin
        m_gc = cv; m_gd = dv; m_rgc = cv; m_rgd = dv;
      end
    end
  endtask

  task automatic model_access(input logic [AW-1:0] a, input logic [WEW-1:0] we, input logic [DW-1:0] wd);
    if (we == 4'h0) begin
      m_rdata = shadow[a];
    end else begin
      m_rdata = 32'h0;
      for (int i = 0; i < WEW; i++)
        if (we[i]) shadow[a][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_wait = 0; m_last = 1'b1; m_pend = 1'b0; m_owner = 1'b0; m_rdata = 32'h0;
    end else begin
      if (!dbg_if.req_valid || m_gd) m_wait = 0;
      else if (m_wait < 15) m_wait++;
      if (m_rgc) m_last = 1'b0;
      else if (m_rgd) m_last = 1'b1;
      m_pend  = m_gc || m_gd;
      m_owner = m_gd;
      if (m_gc) model_access(cpu_if.addr, cpu_if.we, cpu_if.wdata);
      else if (m_gd) model_access(dbg_if.addr, dbg_if.we, dbg_if.wdata);
    end
  endtask

  task automatic drive(input bit cv, input logic [AW-1:0] ca, input logic [WEW-1:0] cwe,
                       input logic [DW-1:0] cwd, input bit dv, input logic [AW-1:0] da,
                       input logic [WEW-1:0] dwe, input logic [DW-1:0] dwd);
    cpu_if.req_valid = cv; cpu_if.addr = ca; cpu_if.we = cwe; cpu_if.wdata = cwd;
    dbg_if.req_valid = dv; dbg_if.addr = da; dbg_if.we = dwe; dbg_if.wdata = dwd;
    #1;
    model_eval();
  endtask

  task automatic idle();
    drive(1'b0, 14'd0, 4'h0, 32'h0, 1'b0, 14'd0, 4'h0, 32'h0);
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 14'd3, 4'h0, 32'h0, 1'b1, 14'd4, 4'hF, 32'h5555AAAA);
    clk_step();
    clk_step();
    checks++;
    if ({cpu_if.req_ready, dbg_if.req_ready, cpu2_if.req_ready, dbg2_if.req_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b%b%b%b want 0000", cpu_if.req_ready, dbg_if.req_ready,
               cpu2_if.req_ready, dbg2_if.req_ready);
    end
    checks++;
    if ({mem_en, mem_we} !== 5'b00000) begin
      errors++; $display("FAIL reset_mem: got en=%b we=%h want 0/0", mem_en, mem_we);
    end
    checks++;
    if ({cpu_if.rvalid, dbg_if.rvalid, cpu_if.rdata, dbg_if.rdata} !== 66'h0) begin
      errors++;
      $display("FAIL reset_resp: got rv=%b%b cpu=%h dbg=%h want zeros", cpu_if.rvalid, dbg_if.rvalid,
               cpu_if.rdata, dbg_if.rdata);
    end
    rst = 1'b0;
    idle();
    clk_step();
  endtask

  task automatic test_cpu_alone();
    drive(1'b1, 14'd5, 4'hF, 32'h11223344, 1'b0, 14'd0, 4'h0, 32'h0);
    checks++;
    if ({cpu_if.req_ready, mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, 4'hF, 14'd5, 32'h11223344}) begin
      errors++;
      $display("FAIL cpu_write_drive: got rdy=%b en=%b we=%h a=%0d d=%h", cpu_if.req_ready, mem_en, mem_we,
               mem_addr, mem_din);
    end
    clk_step();
    drive(1'b1, 14'd5, 4'h0, 32'h0, 1'b0, 14'd0, 4'h0, 32'h0);
    checks++;
    if ({cpu_if.rvalid, cpu_if.rdata, dbg_if.rvalid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL cpu_write_ack: got rv=%b rd=%h dbg_rv=%b want 1/0/0", cpu_if.rvalid, cpu_if.rdata, dbg_if.rvalid);
    end
    clk_step();
    idle();
    checks++;
    if ({cpu_if.rvalid, cpu_if.rdata, dbg_if.rvalid} !== {1'b1, 32'h11223344, 1'b0}) begin
      errors++;
      $display("FAIL cpu_read: got rv=%b rd=%h dbg_rv=%b want 1/11223344/0", cpu_if.rvalid, cpu_if.rdata,
               dbg_if.rvalid);
    end
    clk_step();
    checks++;
    if (cpu_if.rvalid !== 1'b0) begin
      errors++; $display("FAIL cpu_rvalid_pulse: got %b want 0", cpu_if.rvalid);
    end
  endtask

  task automatic test_byte_enables();
    drive(1'b1, 14'd6, 4'b0010, 32'hAABBCCDD, 1'b0, 14'd0, 4'h0, 32'h0);
    clk_step();
    drive(1'b1, 14'd6, 4'h0, 32'h0, 1'b0, 14'd0, 4'h0, 32'h0);
    clk_step();
    idle();
    checks++;
    if (cpu_if.rdata !== 32'h0000CC00) begin
      errors++; $display("FAIL byte_enable: got %h want 0000cc00", cpu_if.rdata);
    end
    clk_step();
  endtask

  task automatic test_starvation();
    for (int cyc = 1; cyc <= 9; cyc++) begin
      drive(1'b1, 14'(10 + cyc), 4'h0, 32'h0, 1'b1, 14'd30, 4'h0, 32'h0);
      checks++;
      if ({cpu_if.req_ready, dbg_if.req_ready} !== ((cyc == 5) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL starvation_grant c%0d: got cpu=%b dbg=%b", cyc, cpu_if.req_ready, dbg_if.req_ready);
      end
      clk_step();
      checks++;
      if ({cpu_if.rvalid, dbg_if.rvalid} !== ((cyc == 5) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL starvation_resp c%0d: got cpu_rv=%b dbg_rv=%b", cyc, cpu_if.rvalid, dbg_if.rvalid);
      end
    end
    idle();
    clk_step();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    idle();
    clk_step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 14'd7, 4'h0, 32'h0, 1'b1, 14'd8, 4'h0, 32'h0);
      checks++;
      if ({cpu2_if.req_ready, dbg2_if.req_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL round_robin k%0d: got cpu=%b dbg=%b", k, cpu2_if.req_ready, dbg2_if.req_ready);
      end
      clk_step();
    end
    idle();
    clk_step();
  endtask

  task automatic test_routing();
    drive(1'b0, 14'd0, 4'h0, 32'h0, 1'b1, 14'd1, 4'hF, 32'hDEADBEEF);
    clk_step();
    drive(1'b1, 14'd2, 4'hF, 32'h12345678, 1'b0, 14'd0, 4'h0, 32'h0);
    clk_step();
    drive(1'b0, 14'd0, 4'h0, 32'h0, 1'b1, 14'd1, 4'h0, 32'h0);
    clk_step();
    drive(1'b1, 14'd2, 4'h0, 32'h0, 1'b0, 14'd0, 4'h0, 32'h0);
    checks++;
    if ({dbg_if.rvalid, dbg_if.rdata, cpu_if.rvalid, cpu_if.rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL route_dbg: got dbg=%b/%h cpu=%b/%h", dbg_if.rvalid, dbg_if.rdata, cpu_if.rvalid, cpu_if.rdata);
    end
    clk_step();
    idle();
    checks++;
    if ({cpu_if.rvalid, cpu_if.rdata, dbg_if.rvalid, dbg_if.rdata} !== {1'b1, 32'h12345678, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL route_cpu: got cpu=%b/%h dbg=%b/%h", cpu_if.rvalid, cpu_if.rdata, dbg_if.rvalid, dbg_if.rdata);
    end
    clk_step();
    checks++;
    if ({cpu_if.rvalid, dbg_if.rvalid} !== 2'b00) begin
      errors++; $display("FAIL route_pulse: got cpu_rv=%b dbg_rv=%b want 00", cpu_if.rvalid, dbg_if.rvalid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 14'd5, 4'h0, 32'h0, 1'b0, 14'd0, 4'h0, 32'h0);
    clk_step();
    rst = 1'b1;
    idle();
    checks++;
    if (cpu_if.rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_drop_a: got cpu_rvalid=%b want 0", cpu_if.rvalid);
    end
    clk_step();
    rst = 1'b0;
    drive(1'b1, 14'd9, 4'h0, 32'h0, 1'b1, 14'd9, 4'h0, 32'h0);
    checks++;
    if (cpu_if.rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_drop_b: got cpu_rvalid=%b want 0", cpu_if.rvalid);
    end
    checks++;
    if ({cpu_if.req_ready, dbg_if.req_ready, cpu2_if.req_ready, dbg2_if.req_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_first_win: got %b%b%b%b want 1010", cpu_if.req_ready, dbg_if.req_ready,
               cpu2_if.req_ready, dbg2_if.req_ready);
    end
    clk_step();
    idle();
    clk_step();
  endtask

  task automatic test_random();
    logic [WEW-1:0] cwe, dwe;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 40) == 0);
      cwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      dwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      drive(1'($urandom), 14'($urandom_range(0, 15)), cwe, $urandom,
            1'($urandom), 14'($urandom_range(0, 15)), dwe, $urandom);
      checks++;
      if ({cpu_if.req_ready, dbg_if.req_ready, cpu2_if.req_ready, dbg2_if.req_ready, mem_en} !==
          {m_gc, m_gd, m_rgc, m_rgd, m_gc | m_gd}) begin
        errors++;
        $display("FAIL rand_grant n%0d: got %b%b%b%b en=%b want %b%b%b%b", n, cpu_if.req_ready, dbg_if.req_ready,
                 cpu2_if.req_ready, dbg2_if.req_ready, mem_en, m_gc, m_gd, m_rgc, m_rgd);
      end
      clk_step();
      checks++;
      if ({cpu_if.rvalid, cpu_if.rdata, dbg_if.rvalid, dbg_if.rdata} !==
          {m_pend && !m_owner && !rst, (m_pend && !m_owner && !rst) ? m_rdata : 32'h0,
           m_pend && m_owner && !rst, (m_pend && m_owner && !rst) ? m_rdata : 32'h0}) begin
        errors++;
        $display("FAIL rand_resp n%0d: got cpu=%b/%h dbg=%b/%h want owner=%b pend=%b data=%h", n, cpu_if.rvalid,
                 cpu_if.rdata, dbg_if.rvalid, dbg_if.rdata, m_owner, m_pend, m_rdata);
      end
    end
    rst = 1'b0;
    idle();
    clk_step();
  endtask

  initial begin
    test_reset();
    test_cpu_alone();
    test_byte_enables();
    test_starvation();
    test_round_robin();
    test_routing();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory block RAM between the CPU load/store port and a debug/loader port driven by the UART bootloader. It sits between the core's memory stage and the dmem BRAM. It owns request arbitration, byte write-enable pass-through, and routing of the 1-cycle-latency read data back to whichever requester issued the read. Starvation of the debug port is bounded by a wait counter.

## Interface
- `ADDR_WIDTH`, default 14: word address width; 16K × 32-bit words.
- `DATA_WIDTH`, default 32: data width.
- `CPU_PRIORITY`, default 1: 1 = fixed priority to CPU with starvation bound; 0 = round-robin.
- `MAX_DBG_WAIT`, default 4: consecutive losing cycles after which the debug port wins. Legal range 1–15.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req_valid`  in  1  CPU request present.
- `cpu_req_ready`  out  1  CPU request accepted this cycle.
- `cpu_addr`  in  ADDR_WIDTH  word address.
- `cpu_we`  in  DATA_WIDTH/8  byte write enables; 0 = read.
- `cpu_wdata`  in  DATA_WIDTH  write data, already lane-aligned.
- `cpu_rvalid`  out  1  response pulse.
- `cpu_rdata`  out  DATA_WIDTH  read data.
- `dbg_req_valid`, `dbg_req_ready`, `dbg_addr`, `dbg_we`, `dbg_wdata`, `dbg_rvalid`, `dbg_rdata`: same as the CPU set, for the debug port.
- `mem_en`  out  1  BRAM enable.
- `mem_we`  out  DATA_WIDTH/8  BRAM byte write enables.
- `mem_addr`  out  ADDR_WIDTH  BRAM address.
- `mem_din`  out  DATA_WIDTH  BRAM write data.
- `mem_dout`  in  DATA_WIDTH  BRAM read data, valid one cycle after `mem_en`.

## Operation
**Arbitration**
- At most one grant per cycle.
- A request is accepted when valid and ready are both high at a rising edge.
- `*_req_ready` is combinational from both valids and the arbiter state.
- `CPU_PRIORITY`=1:
  - CPU wins any conflict, unless `dbg_wait_cnt == MAX_DBG_WAIT`; then debug wins.
  - `dbg_wait_cnt` increments, saturating, each cycle debug is valid and not granted.
  - `dbg_wait_cnt` clears on a debug grant and on any cycle `dbg_req_valid` is 0.
- `CPU_PRIORITY`=0:
  - The `last_grant` register decides conflicts; the port not granted last wins.
  - `last_grant` updates on every grant.
  - Reset value makes the CPU win the first conflict.
- A lone valid requester is always granted, in both modes.

**Memory drive**
- The granted port's addr/we/wdata are muxed to `mem_*`; `mem_en` = grant.
- With no grant: `mem_en`=0, `mem_we`=0, `mem_addr`/`mem_din` = CPU inputs (don't-care).

**Responses**
- Every accepted request (read or write) produces exactly one `*_rvalid` pulse on its own port.
- Registers `resp_pend` and `resp_owner` (0 = CPU, 1 = DBG) capture the accept.
- Reads return `*_rdata` = `mem_dout`.
- Writes return `*_rdata` = 0; the pulse is a write ack.
- The non-owning port's `rdata` reads 0.

## Timing
- Accept in cycle N → `mem_*` driven in cycle N → `rvalid`/`rdata` in cycle N+1 (combinational from `mem_dout` and the response registers).
- Throughput is 1 request/cycle with no bubbles, including back-to-back requests from alternating ports.
- Reset values:
  - `resp_pend`=0, `resp_owner`=0, `dbg_wait_cnt`=0, `last_grant`=DBG.
  - All `*_rvalid`=0; all `rdata`=0; `mem_en`=0, `mem_we`=0.
  - Ready signals are low while `rst`=1.
- Reset asserted while a response is pending: the response is dropped, with no `rvalid` in the following cycle.
- Read and write to the same address in consecutive cycles: the read returns the BRAM's read-first/write-first behaviour unmodified. The arbiter adds no forwarding.

## Structure
- Shared package `riscv_mem_pkg` holds:
  - `DMEM_ADDR_WIDTH` and `DMEM_WE_WIDTH`.
  - Owner encoding `OWNER_CPU`=0, `OWNER_DBG`=1.
- Sub-module `arb2_prio_rr`: two-input grant logic containing `last_grant`, `dbg_wait_cnt` and the `CPU_PRIORITY` mode select. Outputs a one-hot `grant[1:0]`.
- The top level holds the request mux and the response registers.

## Test plan
- **CPU alone:** write 0x11223344 to addr 5 with `we`=4'hF, then read addr 5 → `cpu_rvalid` one cycle after each accept; read `rdata`=0x11223344; `dbg_rvalid` stays 0.
- **Byte enables:** addr 6 preloaded with 0; CPU writes 0xAABBCCDD with `we`=4'b0010 → read returns 0x0000CC00.
- **Starvation bound** (`CPU_PRIORITY`=1, `MAX_DBG_WAIT`=4): CPU and debug both valid continuously → debug granted on the 5th cycle with `cpu_req_ready`=0 that cycle; CPU granted on cycles 1–4 and 6–9.
- **Round-robin** (`CPU_PRIORITY`=0): both ports valid for 6 cycles right after reset → grants C,D,C,D,C,D.
- **Response routing:** debug reads addr 1 (=0xDEADBEEF), then CPU reads addr 2 (=0x12345678) the next cycle → `dbg_rdata`=0xDEADBEEF at N+1 and `cpu_rdata`=0x12345678 at N+2; each `rvalid` is a single-cycle pulse.
- **Reset mid-operation:** `rst` asserted in the cycle after a CPU read is accepted → `cpu_rvalid`=0 throughout; after release, both valid → CPU wins first.
